// File: rtl/cpu_pkg.sv
// Shared fetch-side types: queue/BTB defaults, BTB entry layout, queue entry layout
// and the 2-bit saturating counter trainer.
package cpu_pkg;
    localparam int FQ_DEPTH_DEF    = 4;
    localparam int BTB_ENTRIES_DEF = 64;
    // Wide enough for the smallest legal BTB; unused upper tag bits stay zero.
    localparam int BTB_TAG_W       = 15;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [15:0]          target;
        logic [1:0]           ctr;
    } btb_entry_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] pred;
    } fq_entry_t;

    function automatic logic [1:0] ctr_train(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
        end else begin
            res = (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
        end
        return res;
    endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side bus: instruction memory port, decode handshake, redirect and BTB training.
interface fetch_queue_if;
    logic [14:0] imem_raddr;
    logic [15:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic [15:0] out_pred_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        upd_en;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;

    modport master (
        output imem_raddr,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output out_pred_pc,
        input  redirect,
        input  redirect_pc,
        input  upd_en,
        input  upd_pc,
        input  upd_taken,
        input  upd_target
    );

    modport slave (
        input  imem_raddr,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  out_pred_pc,
        output redirect,
        output redirect_pc,
        output upd_en,
        output upd_pc,
        output upd_taken,
        output upd_target
    );
endinterface

// File: rtl/fetch_queue_btb.sv
// Direct-mapped branch target buffer: combinational lookup port, edge-applied update port.
module btb
    import cpu_pkg::*;
#(
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_lk_pc,
    output logic        o_lk_taken,
    output logic [15:0] o_lk_target,
    input  logic        i_upd_en,
    input  logic [15:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [15:0] i_upd_target
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);

    logic [BTB_ENTRIES-1:0] r_valid;
    logic [BTB_TAG_W-1:0]   r_tag    [BTB_ENTRIES];
    logic [15:0]            r_target [BTB_ENTRIES];
    logic [1:0]             r_ctr    [BTB_ENTRIES];

    logic [IDX_W-1:0]     w_lk_idx;
    logic [IDX_W-1:0]     w_up_idx;
    logic [BTB_TAG_W-1:0] w_lk_tag;
    logic [BTB_TAG_W-1:0] w_up_tag;
    btb_entry_t           w_lk_ent;
    logic                 w_up_hit;
    logic [1:0]           w_up_ctr;

    assign w_lk_idx = i_lk_pc[IDX_W:1];
    assign w_up_idx = i_upd_pc[IDX_W:1];
    assign w_lk_tag = BTB_TAG_W'(i_lk_pc >> (IDX_W + 1));
    assign w_up_tag = BTB_TAG_W'(i_upd_pc >> (IDX_W + 1));

    // Lookup: predict taken only on a tag hit with a counter in the taken half.
    always_comb begin
        w_lk_ent    = '{valid:  r_valid[w_lk_idx],
                        tag:    r_tag[w_lk_idx],
                        target: r_target[w_lk_idx],
                        ctr:    r_ctr[w_lk_idx]};
        o_lk_taken  = w_lk_ent.valid && (w_lk_ent.tag == w_lk_tag) && w_lk_ent.ctr[1];
        o_lk_target = w_lk_ent.target;
    end

    // Training: hits move the counter, misses allocate a fresh weak entry.
    always_comb begin
        w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
        if (w_up_hit) begin
            w_up_ctr = ctr_train(r_ctr[w_up_idx], i_upd_taken);
        end else if (i_upd_taken) begin
            w_up_ctr = 2'd2;
        end else begin
            w_up_ctr = 2'd1;
        end
    end

    // Valid bits are the only reset BTB state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_upd_en) begin
            r_valid[w_up_idx] <= 1'b1;
        end
    end

    // Tag/target/counter storage; a not-taken hit keeps its old target.
    always_ff @(posedge clk) begin
        if (i_upd_en) begin
            r_tag[w_up_idx] <= w_up_tag;
            r_ctr[w_up_idx] <= w_up_ctr;
            if (!w_up_hit || i_upd_taken) begin
                r_target[w_up_idx] <= i_upd_target;
            end
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch: PC register, single in-flight fetch slot, BTB-predicted next PC
// and a small instruction queue feeding decode.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int FQ_DEPTH    = FQ_DEPTH_DEF,
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.master bus
);
    localparam int               PTR_W   = $clog2(FQ_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = FQ_DEPTH[PTR_W:0];

    logic [15:0]      r_pc;
    logic             r_inf_valid;
    logic [15:0]      r_inf_pc;
    logic [15:0]      r_inf_pred;
    fq_entry_t        r_q [FQ_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_btb_taken;
    logic [15:0]      w_btb_target;
    logic [15:0]      w_pred;
    logic [PTR_W:0]   w_occ;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_has_head;
    fq_entry_t        w_head;

    btb #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_lk_pc      (r_pc),
        .o_lk_taken   (w_btb_taken),
        .o_lk_target  (w_btb_target),
        .i_upd_en     (bus.upd_en),
        .i_upd_pc     (bus.upd_pc),
        .i_upd_taken  (bus.upd_taken),
        .i_upd_target (bus.upd_target)
    );

    assign bus.imem_raddr = r_pc[15:1];
    assign w_pred         = w_btb_taken ? w_btb_target : r_pc + 16'd2;
    // The in-flight fetch already owns a queue slot, so it counts toward occupancy.
    assign w_occ          = r_count + {{PTR_W{1'b0}}, r_inf_valid};
    assign w_issue        = !bus.redirect && (w_occ < DEPTH_C);
    assign w_push         = r_inf_valid && !bus.redirect;
    assign w_has_head     = (r_count != '0);
    assign w_pop          = w_has_head && bus.out_ready && !bus.redirect;

    // PC, in-flight slot and queue bookkeeping; redirect overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= 16'h0000;
            r_inf_valid <= 1'b0;
            r_inf_pc    <= 16'h0000;
            r_inf_pred  <= 16'h0000;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
        end else if (bus.redirect) begin
            r_pc        <= bus.redirect_pc;
            r_inf_valid <= 1'b0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
        end else begin
            r_inf_valid <= w_issue;
            if (w_issue) begin
                r_pc       <= w_pred;
                r_inf_pc   <= r_pc;
                r_inf_pred <= w_pred;
            end
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1'b1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{PTR_W{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{PTR_W{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage; emptiness is tracked by r_count so entries need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q[r_tail] <= '{pc: r_inf_pc, instr: bus.imem_rdata, pred: r_inf_pred};
        end
    end

    // Head presentation, forced to zero whenever the queue is empty.
    always_comb begin
        w_head        = r_q[r_head];
        bus.out_valid = w_has_head;
        if (w_has_head) begin
            bus.out_pc      = w_head.pc;
            bus.out_instr   = w_head.instr;
            bus.out_pred_pc = w_head.pred;
        end else begin
            bus.out_pc      = 16'h0000;
            bus.out_instr   = 16'h0000;
            bus.out_pred_pc = 16'h0000;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming/back-pressure vector table, then
// hand-written BTB training, redirect and mid-stream reset sequences.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_queue_if bus ();

    fetch_queue #(
        .FQ_DEPTH    (4),
        .BTB_ENTRIES (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle latency, word content = 0x1000 + byte PC.
    always @(posedge clk) begin
        bus.imem_rdata <= 16'h1000 + {bus.imem_raddr, 1'b0};
    end

    typedef struct {
        logic        rdy;
        logic        exp_v;
        logic [15:0] exp_pc;
        logic [14:0] exp_ra;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic head_chk(input string name, input logic v, input logic [15:0] pc,
                            input logic [15:0] pred);
        chk({name, "_valid"}, {15'd0, bus.out_valid}, {15'd0, v});
        chk({name, "_pc"},    bus.out_pc,      v ? pc : 16'h0000);
        chk({name, "_instr"}, bus.out_instr,   v ? 16'h1000 + pc : 16'h0000);
        chk({name, "_pred"},  bus.out_pred_pc, v ? pred : 16'h0000);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
        bus.upd_en     = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_taken  = taken;
        bus.upd_target = tgt;
    endtask

    // Redirect for one cycle; returns in the cycle the target should reach the head.
    task automatic do_redirect(input logic [15:0] tgt);
        logic [15:0] t;
        t = tgt;
        bus.redirect    = 1'b1;
        bus.redirect_pc = t;
        next_cycle();
        bus.redirect = 1'b0;
        bus.upd_en   = 1'b0;
        head_chk("redir_r1", 1'b0, 16'h0000, 16'h0000);
        chk("redir_r1_raddr", {1'b0, bus.imem_raddr}, {1'b0, t[15:1]});
        next_cycle();
        head_chk("redir_r2", 1'b0, 16'h0000, 16'h0000);
        next_cycle();
        head_chk("redir_r3", 1'b1, t, t + 16'h0002);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 15'h0000};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 15'h0001};
        vecs[2]  = '{1'b1, 1'b1, 16'h0000, 15'h0002};
        vecs[3]  = '{1'b1, 1'b1, 16'h0002, 15'h0003};
        vecs[4]  = '{1'b1, 1'b1, 16'h0004, 15'h0004};
        vecs[5]  = '{1'b1, 1'b1, 16'h0006, 15'h0005};
        vecs[6]  = '{1'b0, 1'b1, 16'h0008, 15'h0006};
        vecs[7]  = '{1'b0, 1'b1, 16'h0008, 15'h0007};
        vecs[8]  = '{1'b0, 1'b1, 16'h0008, 15'h0008};
        vecs[9]  = '{1'b0, 1'b1, 16'h0008, 15'h0008};
        vecs[10] = '{1'b0, 1'b1, 16'h0008, 15'h0008};
        vecs[11] = '{1'b0, 1'b1, 16'h0008, 15'h0008};
        vecs[12] = '{1'b0, 1'b1, 16'h0008, 15'h0008};
        vecs[13] = '{1'b0, 1'b1, 16'h0008, 15'h0008};
        vecs[14] = '{1'b0, 1'b1, 16'h0008, 15'h0008};
        vecs[15] = '{1'b0, 1'b1, 16'h0008, 15'h0008};
        vecs[16] = '{1'b1, 1'b1, 16'h0008, 15'h0008};
        vecs[17] = '{1'b1, 1'b1, 16'h000A, 15'h0008};
        vecs[18] = '{1'b1, 1'b1, 16'h000C, 15'h0009};
        vecs[19] = '{1'b1, 1'b1, 16'h000E, 15'h000A};
        vecs[20] = '{1'b1, 1'b1, 16'h0010, 15'h000B};
        vecs[21] = '{1'b1, 1'b1, 16'h0012, 15'h000C};

        rst_n           = 1'b0;
        bus.out_ready   = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.upd_en      = 1'b0;
        bus.upd_pc      = 16'h0000;
        bus.upd_taken   = 1'b0;
        bus.upd_target  = 16'h0000;

        next_cycle();
        next_cycle();
        head_chk("reset", 1'b0, 16'h0000, 16'h0000);
        chk("reset_raddr", {1'b0, bus.imem_raddr}, 16'h0000);
        rst_n = 1'b1;

        // Streaming, then 10 cycles of back-pressure, then resume.
        for (int i = 0; i < 22; i++) begin
            bus.out_ready = vecs[i].rdy;
            head_chk($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_pc,
                     vecs[i].exp_pc + 16'h0002);
            chk($sformatf("vec%0d_raddr", i), {1'b0, bus.imem_raddr}, {1'b0, vecs[i].exp_ra});
            next_cycle();
        end

        // Train 0x0010: taken, taken, not-taken (target must not change).
        set_upd(16'h0010, 1'b1, 16'h0040);
        next_cycle();
        next_cycle();
        set_upd(16'h0010, 1'b0, 16'h7777);
        next_cycle();
        bus.upd_en = 1'b0;
        do_redirect(16'h000C);
        next_cycle();
        next_cycle();
        head_chk("btb_taken", 1'b1, 16'h0010, 16'h0040);
        next_cycle();
        head_chk("btb_follow", 1'b1, 16'h0040, 16'h0042);

        // Second not-taken update lands in the same cycle as a redirect.
        set_upd(16'h0010, 1'b0, 16'h7777);
        do_redirect(16'h000C);
        next_cycle();
        next_cycle();
        head_chk("btb_untrained", 1'b1, 16'h0010, 16'h0012);
        next_cycle();
        head_chk("btb_untrained_next", 1'b1, 16'h0012, 16'h0014);

        // Retrain 0x0010, then an aliasing update from 0x0090 replaces it.
        set_upd(16'h0010, 1'b1, 16'h0040);
        next_cycle();
        set_upd(16'h0090, 1'b1, 16'h0080);
        next_cycle();
        bus.upd_en = 1'b0;
        do_redirect(16'h000C);
        next_cycle();
        next_cycle();
        head_chk("alias_old", 1'b1, 16'h0010, 16'h0012);
        do_redirect(16'h008C);
        next_cycle();
        next_cycle();
        head_chk("alias_new", 1'b1, 16'h0090, 16'h0080);
        next_cycle();
        head_chk("alias_follow", 1'b1, 16'h0080, 16'h0082);

        // Fill the queue, then redirect with out_ready high in the same cycle.
        bus.out_ready = 1'b0;
        repeat (8) next_cycle();
        head_chk("full_head", 1'b1, 16'h0080, 16'h0082);
        chk("full_raddr", {1'b0, bus.imem_raddr}, 16'h0044);
        bus.out_ready = 1'b1;
        do_redirect(16'h0200);
        next_cycle();
        head_chk("redir_next", 1'b1, 16'h0202, 16'h0204);

        // Make 0x0010 predict taken, half-fill the queue, then reset mid-cycle.
        set_upd(16'h0010, 1'b1, 16'h0040);
        next_cycle();
        next_cycle();
        bus.upd_en    = 1'b0;
        bus.out_ready = 1'b0;
        next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        head_chk("midreset", 1'b0, 16'h0000, 16'h0000);
        chk("midreset_raddr", {1'b0, bus.imem_raddr}, 16'h0000);
        bus.out_ready = 1'b1;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 13; k++) begin
            logic [15:0] epc;
            epc = 16'(2 * (k - 2));
            head_chk($sformatf("restart%0d", k), (k >= 2), epc, epc + 16'h0002);
            chk($sformatf("restart%0d_raddr", k), {1'b0, bus.imem_raddr}, 16'(k));
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter FQ_DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-002 SHALL have parameter BTB_ENTRIES, default 64, direct-mapped BTB entries (power of two).
REQ-003 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_raddr  output  15  instruction word address, pc[15:1].
REQ-006 SHALL have port imem_rdata  input  16  instruction word, valid one cycle after imem_raddr.
REQ-007 SHALL have port out_valid  output  1  queue head holds a valid instruction.
REQ-008 SHALL have port out_ready  input  1  decode accepts head this cycle.
REQ-009 SHALL have port out_pc  output  16  PC of head instruction.
REQ-010 SHALL have port out_instr  output  16  head instruction.
REQ-011 SHALL have port out_pred_pc  output  16  predicted next PC for head.
REQ-012 SHALL have port redirect  input  1  writeback flush request.
REQ-013 SHALL have port redirect_pc  input  16  corrected fetch PC.
REQ-014 SHALL have port upd_en  input  1  resolved-jump training strobe.
REQ-015 SHALL have port upd_pc  input  16  PC of resolved jump.
REQ-016 SHALL have port upd_taken  input  1  jump resolved taken.
REQ-017 SHALL have port upd_target  input  16  resolved jump target.

Function
REQ-018 SHALL hold fetch PC register; imem_raddr = pc[15:1] combinationally each cycle.
REQ-019 SHALL issue a fetch in any cycle where (queue count + in-flight) < FQ_DEPTH and redirect=0; otherwise pc holds and no in-flight entry is created.
REQ-020 SHALL, on issue, capture {pc, pred} into a single in-flight register; next cycle push {pc, imem_rdata, pred} into the queue.
REQ-021 SHALL compute pred = BTB hit (valid & tag==pc[15:idx+1]) & counter>=2 ? stored target : pc+2 (16-bit wrap, 0xFFFE+2=0x0000); pc <= pred on issue.
REQ-022 SHALL index BTB with pc[log2(BTB_ENTRIES):1]; tag = remaining upper PC bits.
REQ-023 SHALL present queue head on out_*; pop when out_valid & out_ready; push and pop same cycle when full is legal, count unchanged.
REQ-024 SHALL, on redirect, discard queue contents and in-flight fetch, set pc <= redirect_pc; out_valid=0 the following cycle; redirect_pc issued the cycle after redirect, out_valid for it 3 cycles after redirect cycle.
REQ-025 SHALL give redirect priority over push, pop and issue in the same cycle.
REQ-026 SHALL, on upd_en with tag miss/invalid, allocate entry: valid=1, tag, target=upd_target, counter=upd_taken?2:1.
REQ-027 SHALL, on upd_en with tag hit, saturating increment (max 3) if taken else decrement (min 0); overwrite target only when taken.
REQ-028 SHALL apply BTB writes at the clock edge; same-cycle lookup of the updated index sees the old entry.
REQ-029 SHALL process upd_en and redirect independently when simultaneous.
REQ-030 SHALL never drop or duplicate an instruction absent redirect.

Reset
REQ-031 SHALL, while rst_n=0: pc=0x0000, queue empty, in-flight invalid, all BTB valid bits 0, out_valid=0, out_pc/out_instr/out_pred_pc=0.
REQ-032 SHALL issue address 0 in the first cycle after rst_n release; out_valid first high 2 cycles later.
REQ-033 SHALL leave BTB tag/target/counter arrays unreset.
REQ-034 SHALL abort any in-flight fetch on mid-operation reset.

Structure
REQ-035 SHALL take FQ_DEPTH, BTB_ENTRIES defaults and the BTB entry struct {valid, tag, target[15:0], ctr[1:0]} from shared package cpu_pkg.
REQ-036 SHALL implement the BTB as sub-module btb (lookup port + update port); queue and PC logic stay in fetch_queue.

Verification
REQ-037 Reset release, out_ready=1, imem returns 0x1000+addr -> out_pc 0,2,4,... from cycle 2, one per cycle, out_pred_pc=out_pc+2.
REQ-038 out_ready=0 for 10 cycles -> exactly 4 entries queued, imem_raddr frozen; out_ready=1 -> PCs continue in order, none lost.
REQ-039 upd_en pc=0x0010 taken target=0x0040 twice -> next fetch of 0x0010 shows out_pred_pc=0x0040, following out_pc=0x0040; two not-taken updates -> pred back to 0x0012.
REQ-040 redirect pc=0x0200 with full queue and out_ready=1 same cycle -> out_valid=0 next cycle, first out_pc=0x0200 exactly 3 cycles after redirect.
REQ-041 Aliased update pc=0x0090 (same index as 0x0010, new tag) -> entry replaced, counter=2; fetch of 0x0010 predicts 0x0012.
REQ-042 rst_n asserted mid-stream with queue half full -> outputs zero immediately; after release fetch restarts at 0x0000 with no BTB predictions.
